// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and the
// instruction handshake toward decode.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rsp_valid;
   logic [15:0]       mem_rsp_data;

   logic              inst_valid;
   logic              inst_ready;
   logic [15:0]       inst_data;
   logic [ADDR_W-1:0] inst_pc;

   // master = fetch sequencer; slave = memory + decode side
   modport master (
      output mem_req_valid, mem_addr, inst_valid, inst_data, inst_pc,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
   );

   modport slave (
      input  mem_req_valid, mem_addr, inst_valid, inst_data, inst_pc,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one memory read per instruction
// and hands the captured word to decode. Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_sequencer #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 2
) (
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       stall_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic              req_valid_q;
   logic              inst_valid_q;
   logic              busy_q;
   logic [15:0]       inst_data_q;
   logic [ADDR_W-1:0] inst_pc_q;
   logic              capture;
   logic              req_fire;

   // req_valid_q is low in the REQ state only for the first cycle after reset,
   // so that cycle is a REQ entry point where halt is still honoured.
   assign req_fire = req_valid_q && bus.mem_req_ready;

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the case statements can infer a latch.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      capture   = 1'b0;

      case (state)
         IDLE: if (!halt) state_nxt = REQ;
         REQ: begin
            if (req_fire)                state_nxt = WAIT;
            else if (!req_valid_q && halt) state_nxt = IDLE;
         end
         WAIT: begin
            if (bus.mem_rsp_valid) begin
               state_nxt = HOLD;
               capture   = 1'b1;
            end
         end
         HOLD: begin
            if (bus.inst_ready) begin
               pc_nxt    = pc + ADDR_W'(PC_STEP);
               state_nxt = halt ? IDLE : REQ;
            end
         end
         DRAIN: if (bus.mem_rsp_valid) state_nxt = halt ? IDLE : REQ;
         default: state_nxt = REQ;
      endcase

      // Redirect overrides everything above; an issued request is never
      // abandoned, its response is drained instead.
      if (redirect_valid) begin
         pc_nxt  = redirect_pc;
         capture = 1'b0;
         case (state)
            IDLE, REQ: state_nxt = req_fire ? DRAIN : (halt ? IDLE : REQ);
            WAIT:      state_nxt = bus.mem_rsp_valid ? REQ : DRAIN;
            HOLD:      state_nxt = halt ? IDLE : REQ;
            default:   ;
         endcase
      end
   end

   // NOTE: state and outputs are sequential, so they use non-blocking
   // assignments; blocking here would race with other clocked readers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= REQ;
         pc           <= RESET_PC;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         inst_data_q  <= '0;
         inst_pc_q    <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         req_valid_q  <= (state_nxt == REQ);
         inst_valid_q <= (state_nxt == HOLD);
         busy_q       <= (state_nxt != IDLE);
         if (capture) begin
            inst_data_q <= bus.mem_rsp_data;
            inst_pc_q   <= pc;
         end
      end
   end

   assign bus.mem_req_valid = req_valid_q;
   assign bus.mem_addr      = pc;
   assign bus.inst_valid    = inst_valid_q;
   assign bus.inst_data     = inst_data_q;
   assign bus.inst_pc       = inst_pc_q;
   assign busy              = busy_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_q <= '0;
         stall_q <= '0;
      end else begin
         if (inst_valid_q && bus.inst_ready && !redirect_valid)
            fetch_q <= fetch_q + 32'd1;
         if ((req_valid_q && !bus.mem_req_ready) || (inst_valid_q && !bus.inst_ready))
            stall_q <= stall_q + 32'd1;
      end
   end

   assign fetch_count = fetch_q;
   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed timing scenarios followed by
// randomized traffic checked against a transaction-level fetch/memory model.
module tb_fetch_sequencer;
   localparam int          ADDR_W   = 16;
   localparam logic [15:0] RESET_PC = 16'h0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   always #5 clk = ~clk;

   fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_sequencer #(
      .ADDR_W  (ADDR_W),
      .RESET_PC(RESET_PC),
      .PC_STEP (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .halt          (halt),
      .busy          (busy)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count),
      .stall_count   (stall_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Contents of instruction memory as a function of address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C5A;
   endfunction

   // memory model
   bit          pend;
   logic [15:0] pend_addr;
   int          pend_wait;
   int          lat = 1;
   bit          override_next;
   bit          rand_mode;
   // fetch-stream reference
   logic [15:0] exp_addr;
   logic [15:0] last_acc;
   bit          deliverable;
   int          delivered;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;

   logic [8:0]  iv_seen;
   logic [15:0] addr_log[3];
   logic [15:0] ipc_log[3];

   // One clock cycle: update the reference from what the edge will sample,
   // cross the edge, check post-edge invariants, drive the next cycle's inputs.
   task automatic tick();
      bit          pre_rst, acc, hs, redir, pre_halt, pre_iv, hold_req, hold_inst;
      logic [15:0] pre_addr, pre_ipc, pre_idata, pre_rpc;
      pre_rst   = reset;
      acc       = bus.mem_req_valid && bus.mem_req_ready;
      hs        = bus.inst_valid && bus.inst_ready;
      redir     = redirect_valid;
      pre_halt  = halt;
      pre_iv    = bus.inst_valid;
      hold_req  = bus.mem_req_valid && !bus.mem_req_ready;
      hold_inst = bus.inst_valid && !bus.inst_ready;
      pre_addr  = bus.mem_addr;
      pre_ipc   = bus.inst_pc;
      pre_idata = bus.inst_data;
      pre_rpc   = redirect_pc;

      if (!pre_rst) begin
         exp_addr    = RESET_PC;
         deliverable = 1'b0;
         m_fetch     = '0;
         m_stall     = '0;
      end else begin
         if (bus.mem_req_valid === 1'b1) check("req_addr", bus.mem_addr, exp_addr);
         if (hold_req || hold_inst) m_stall = m_stall + 32'd1;
         if (acc) begin
            last_acc    = pre_addr;
            deliverable = 1'b1;
         end
         if (hs) begin
            check("deliver_once", deliverable, 1);
            check("inst_pc", pre_ipc, last_acc);
            check("inst_data", pre_idata, mem_word(pre_ipc));
            deliverable = 1'b0;
            delivered++;
            exp_addr = pre_ipc + 16'd2;
            if (!redir) m_fetch = m_fetch + 32'd1;
         end
         if (redir) begin
            exp_addr    = pre_rpc;
            deliverable = 1'b0;
         end
      end

      @(posedge clk);
      #1;

      if (pre_rst) begin
         if (hold_req && !redir)
            check("req_hold", {bus.mem_req_valid, bus.mem_addr}, {1'b1, pre_addr});
         if (hold_req && redir && !pre_halt)
            check("req_redir", {bus.mem_req_valid, bus.mem_addr}, {1'b1, pre_rpc});
         if (hold_inst && !redir)
            check("inst_hold", {bus.inst_valid, bus.inst_pc, bus.inst_data},
                  {1'b1, pre_ipc, pre_idata});
         if (pre_iv && redir) check("redir_drop", bus.inst_valid, 0);
      end

      bus.mem_rsp_valid = 1'b0;
      if (!pre_rst) pend = 1'b0;
      if (pre_rst && acc) begin
         pend      = 1'b1;
         pend_addr = pre_addr;
         pend_wait = rand_mode ? int'($urandom_range(0, 2)) : lat - 1;
      end
      if (pend) begin
         if (pend_wait == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = override_next ? 16'hDEAD : mem_word(pend_addr);
            override_next     = 1'b0;
            pend              = 1'b0;
         end else begin
            pend_wait--;
         end
      end else if (rand_mode && $urandom_range(0, 19) == 0) begin
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_data  = 16'hBAD1;
      end

      if (rand_mode) begin
         bus.mem_req_ready = ($urandom_range(0, 9) < 7);
         bus.inst_ready    = ($urandom_range(0, 9) < 6);
         redirect_valid    = ($urandom_range(0, 19) == 0);
         redirect_pc       = 16'($urandom) & 16'hFFFE;
         if ($urandom_range(0, 49) == 0) halt = ~halt;
      end
   endtask

   initial begin
      reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      bus.mem_req_ready = 1'b0; bus.inst_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      exp_addr = RESET_PC; last_acc = '0; deliverable = 1'b0; delivered = 0;
      m_fetch = '0; m_stall = '0; pend = 1'b0; pend_wait = 0; override_next = 1'b0;
      rand_mode = 1'b0;

      // reset values
      repeat (3) tick();
      check("rst_outputs", {bus.mem_req_valid, busy, bus.inst_valid}, 3'b000);
      check("rst_inst_data", bus.inst_data, 16'h0000);
      check("rst_inst_pc", bus.inst_pc, 16'h0000);

      // release: request at RESET_PC one cycle later
      reset = 1'b1; bus.mem_req_ready = 1'b1; bus.inst_ready = 1'b1; lat = 1;
      tick();
      check("rel_req", {bus.mem_req_valid, busy, bus.mem_addr}, {2'b11, RESET_PC});

      // back-to-back fetch, one instruction per 3 cycles
      for (int k = 0; k < 9; k++) begin
         iv_seen[k] = bus.inst_valid;
         if (k % 3 == 0) addr_log[k/3] = bus.mem_req_valid ? bus.mem_addr : 16'hFFFF;
         if (k % 3 == 2) ipc_log[k/3] = bus.inst_pc;
         tick();
      end
      check("iv_pattern", iv_seen, 9'b100_100_100);
      for (int i = 0; i < 3; i++) begin
         check("seq_addr", addr_log[i], RESET_PC + 16'(2 * i));
         check("seq_inst_pc", ipc_log[i], RESET_PC + 16'(2 * i));
      end

      // memory back-pressure for 5 cycles
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_req", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'h0106});
         tick();
      end
`ifdef FETCH_PERF_CNT_EN
      check("stall_count", stall_count, 5);
      check("fetch_count", fetch_count, 3);
`endif
      bus.mem_req_ready = 1'b1;
      tick();

      // decode back-pressure for 4 cycles in HOLD
      bus.inst_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("hold_stall", {bus.inst_valid, bus.mem_req_valid, bus.inst_pc, bus.inst_data},
               {2'b10, 16'h0106, mem_word(16'h0106)});
         tick();
      end
      bus.inst_ready = 1'b1;
      tick();
      check("after_hold", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'h0108});

      // redirect while waiting; the late response (0xDEAD) must be dropped
      lat = 3; override_next = 1'b1;
      tick();
      redirect_valid = 1'b1; redirect_pc = 16'h2000;
      tick();
      redirect_valid = 1'b0;
      check("drain_no_req", bus.mem_req_valid, 0);
      tick();
      check("drain_wait", bus.mem_req_valid, 0);
      lat = 1;
      tick();
      check("redir_addr", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'h2000});
      check("no_dead", bus.inst_data, mem_word(16'h0106));
      tick();
      tick();
      check("redir_fetch", {bus.inst_valid, bus.inst_pc, bus.inst_data},
            {1'b1, 16'h2000, mem_word(16'h2000)});
      tick();

      // halt raised while waiting: instruction still delivered, then idle
      lat = 2;
      tick();
      halt = 1'b1;
      tick();
      check("lat2_wait", bus.inst_valid, 0);
      tick();
      check("halt_deliver", {bus.inst_valid, bus.inst_pc}, {1'b1, 16'h2002});
      tick();
      for (int i = 0; i < 3; i++) begin
         check("halt_idle", {busy, bus.mem_req_valid}, 2'b00);
         tick();
      end
      halt = 1'b0;
      tick();
      check("resume", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'h2004});

      // PC wrap from 0xFFFE
      bus.mem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      check("wrap_req", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'hFFFE});
      bus.mem_req_ready = 1'b1; lat = 1;
      tick();
      tick();
      check("wrap_hold", {bus.inst_valid, bus.inst_pc}, {1'b1, 16'hFFFE});
      tick();
      check("wrap_addr", {bus.mem_req_valid, bus.mem_addr}, {1'b1, 16'h0000});

      // reset in the middle of a wait
      lat = 2;
      tick();
      reset = 1'b0;
      tick();
      check("midrst", {bus.inst_valid, bus.mem_req_valid, busy, bus.inst_pc}, 19'h0);
      reset = 1'b1;
      tick();
      check("midrst_rel", {bus.mem_req_valid, bus.mem_addr}, {1'b1, RESET_PC});

      // randomized traffic
      rand_mode = 1'b1;
      repeat (4000) tick();
      check("progress", delivered > 50, 1);
`ifdef FETCH_PERF_CNT_EN
      check("rand_fetch_count", fetch_count, m_fetch);
      check("rand_stall_count", stall_count, m_stall);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
